// File: rtl/load_store_unit.sv
// load_store_unit: single-transaction memory stage with lane steering, extension, LWL/LWR merge and store byte-enables
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  loadcontrol,
  input  logic [1:0]  store_size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rt_old,
  input  logic [15:0] imm,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_error,
  output logic        bus_error
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0] lc;
  logic [1:0] k;
  logic [31:0] rto, bsh, lwl, lwr, fmt;
  logic [15:0] h;
  logic [7:0] b;
  logic [4:0] sh;
  logic is_lui, mis, to, aerr, berr;
  assign avm_read = state == RD;
  assign avm_write = state == WR;
  assign busy = state != IDLE;
  assign done = state == RESP;
  assign addr_error = done && aerr;
  assign bus_error = done && berr;
  // request classification, timeout detection and next state
  always_comb begin
    is_lui = !is_store && loadcontrol == 3'b100;
    mis = is_store ? (store_size == 2'b01 ? addr[0] : store_size[1] ? |addr[1:0] : 1'b0)
                   : (loadcontrol[2:1] == 2'b01 ? addr[0] : loadcontrol == 3'b101 ? |addr[1:0] : 1'b0);
    to = TIMEOUT_CYCLES != 0 && avm_waitrequest && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    nxt = state;
    if (state == IDLE)
      nxt = !start ? IDLE : (is_lui || mis) ? RESP : is_store ? WR : RD;
    else if (state == RD || state == WR)
      nxt = (!avm_waitrequest || to) ? RESP : state;
    else
      nxt = IDLE;
  end
  // load result formatting from the returned word and the latched lane
  always_comb begin
    sh = {k, 3'b000};
    bsh = avm_readdata >> sh;
    b = bsh[7:0];
    h = k[1] ? avm_readdata[31:16] : avm_readdata[15:0];
    lwl = (avm_readdata << (5'd24 - sh)) | (rto & (ONES >> ({1'b0, sh} + 6'd8)));
    lwr = bsh | (rto & ~(ONES >> sh));
    fmt = lc == 3'b000 ? {{24{b[7]}}, b} :
          lc == 3'b001 ? {24'h0, b} :
          lc == 3'b010 ? {{16{h[15]}}, h} :
          lc == 3'b011 ? {16'h0, h} :
          lc == 3'b110 ? lwl :
          lc == 3'b111 ? lwr : avm_readdata;
  end
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  // request latch, bus drive registers, wait counter and result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_address <= '0;
      avm_writedata <= '0;
      avm_byteenable <= '0;
      lc <= '0;
      k <= '0;
      rto <= '0;
      cnt <= '0;
      rdata <= '0;
      aerr <= 1'b0;
      berr <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        avm_address <= {addr[31:2], 2'b00};
        avm_writedata <= store_size == 2'b00 ? {4{wdata[7:0]}} : store_size == 2'b01 ? {2{wdata[15:0]}} : wdata;
        avm_byteenable <= !is_store ? 4'hF : store_size == 2'b00 ? 4'b0001 << addr[1:0] :
                          store_size == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'hF;
        lc <= loadcontrol;
        k <= addr[1:0];
        rto <= rt_old;
        cnt <= '0;
        aerr <= mis;
        berr <= 1'b0;
        if (is_lui) rdata <= {imm, 16'h0};
      end
    end else if (state == RD || state == WR) begin
      if (avm_waitrequest) cnt <= cnt + 1'b1;
      if (to) berr <= 1'b1;
      if (state == RD && !avm_waitrequest) rdata <= fmt;
    end
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage downstream of the main decoder.
- Consumes the decoder's `loadcontrol` encoding plus store-size information and the computed effective address.
- Performs one Avalon-MM style data-bus transaction per request: byte lanes, sign/zero extension, LWL/LWR merge and store byte-enables.
- Returns the register-file write value, or signals a fault.

Parameters:
- `TIMEOUT_CYCLES`, 0: maximum consecutive `avm_waitrequest` cycles tolerated in RD/WR before abort; 0 disables the timeout.
- `CNT_W`, 16: width of the wait counter; `TIMEOUT_CYCLES` < 2^`CNT_W`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe, sampled only in IDLE.
- `is_store`  in  1  1 = store, 0 = load.
- `loadcontrol`  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LUI, 101 LW, 110 LWL, 111 LWR.
- `store_size`  in  2  00 SB, 01 SH, 10 SW, 11 reserved (treated as SW).
- `addr`  in  32  effective byte address.
- `wdata`  in  32  rt value to store.
- `rt_old`  in  32  current rt value, used for LWL/LWR merge.
- `imm`  in  16  immediate, used for LUI.
- `avm_address`  out  32  word-aligned bus address ({addr[31:2],2'b00}).
- `avm_read`  out  1  bus read request.
- `avm_write`  out  1  bus write request.
- `avm_writedata`  out  32  store data, lane-replicated.
- `avm_byteenable`  out  4  active byte lanes.
- `avm_waitrequest`  in  1  slave stall.
- `avm_readdata`  in  32  valid in the cycle read is held with waitrequest low.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  load/LUI result, held until the next completed load.
- `addr_error`  out  1  misaligned access, valid with `done`.
- `bus_error`  out  1  timeout abort, valid with `done`.

Behaviour:
- Reset (async, `reset_n`=0): state=IDLE, all outputs 0, wait counter 0; takes effect immediately, including mid-transaction (read/write drop in the same cycle).
- Byte lane k = addr[1:0]. Lane 0 = bits[7:0] (little-endian lanes).
- IDLE: on `start`, latch all request inputs, clear the wait counter, then branch:
  - LUI (load, lc=100): go to RESP with result {imm,16'h0}; no bus access.
  - Misaligned (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0): go to RESP with `addr_error`=1; no bus access; `rdata` unchanged.
  - LWL/LWR/LB/LBU are never misaligned.
  - Other load → RD; store → WR.
- `start` while busy is ignored.
- RD: `avm_read`=1, byteenable=4'hF. On the first cycle with waitrequest=0, capture the formatted result and go to RESP.
- Load formatting, with W = readdata and byte = W[8k+7:8k]:
  - LB / LBU: sign- / zero-extend byte.
  - LH / LHU: extend W[16·(k/2)+15 : 16·(k/2)].
  - LW: W.
  - LWL: (W << 8·(3−k)) | (rt_old & (32'hFFFFFFFF >> 8·(k+1))), where (k=3) → no rt_old bytes.
  - LWR: (W >> 8k) | (rt_old & ~(32'hFFFFFFFF >> 8k)).
- WR: `avm_write`=1; data and byteenable by `store_size`:
  - SB: data {4{wdata[7:0]}}, byteenable 1<<k.
  - SH: data {2{wdata[15:0]}}, byteenable 0011 (k=0) or 1100 (k=2).
  - SW: data wdata, byteenable 1111.
  - Completes on the first cycle with waitrequest=0, then → RESP.
- Bus outputs are registered and stable while waitrequest=1.
- Timeout: in RD/WR each waitrequest=1 cycle increments the counter. If `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES`, deassert read/write next cycle, go to RESP with `bus_error`=1, `rdata` unchanged.
- RESP: `done`=1 for exactly one cycle, errors valid alongside, then → IDLE. `addr_error`/`bus_error` are 0 outside RESP.
- Latency with zero wait states:
  - load/store: start@0, bus request@1, done@2.
  - LUI/misaligned: done@1.
- Each waitrequest cycle adds one cycle.
- Back-to-back: `start` may be asserted in the cycle after `done`.

Test Plan:
1. LB at addr 0x...3, readdata=32'h80_11_22_33, waitrequest=0 → read@1, byteenable F, done@2, rdata=32'hFFFFFF80; LBU → 32'h00000080.
2. SH at addr 0x...2, wdata=32'hxxxxBEEF, waitrequest high 3 cycles → write held 4 cycles with writedata 32'hBEEFBEEF, byteenable 1100, done 1 cycle after waitrequest drops.
3. LWL addr k=1, W=32'hAABBCCDD, rt_old=32'h11223344 → rdata=32'hCCDD3344; LWR k=1 → rdata=32'h11AABBCC.
4. LW at addr 0x...6 → no read asserted, done@1 with addr_error=1; LUI imm=16'h1234 → done@1, rdata=32'h12340000.
5. `TIMEOUT_CYCLES`=4, waitrequest stuck high in RD → read asserted 4 cycles, then dropped, done with bus_error=1, rdata unchanged.
6. `reset_n` low during WR with waitrequest=1 → avm_write=0 immediately, busy=0, no done; after release a new request completes normally.
